avmm_single_write_fsm: RTL

Executes one Avalon-MM write transaction per start pulse. The upstream multi-write sequencer uses it as its write engine. Address, byte-enable and data are captured on start. The block then drives the Avalon-MM write until the slave deasserts waitrequest, and reports completion with a one-cycle done pulse. An optional timeout stops a stalled transfer and reports an error.

---
 rtl/avmm_single_write_fsm.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/avmm_single_write_fsm.sv
// -----------------------------------------------------------------------------
// avmm_single_write_fsm
//
// Write engine for the multi-write sequencer. Each start pulse taken in IDLE
// captures address, byte-enable and data and drives one Avalon-MM write. The
// write is held until the slave drops waitrequest. Completion is reported with
// a one-cycle done pulse.
//
// Build option:
//   AVMM_WRITE_TIMEOUT_EN - when defined, a stalled write is abandoned after
//                           TIMEOUT_CYCLES cycles of avmm_write. done and
//                           error then pulse together. When undefined, the
//                           write waits indefinitely and error stays 0.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              request pulse, sampled only in IDLE
//   addr_in/be_in/
//   data_in            transaction fields, captured with start
//   busy               high in every state except IDLE
//   done               one-cycle pulse at transaction end
//   error              pulses with done when the transfer timed out
//   avmm_address/
//   avmm_byteenable/
//   avmm_writedata     registered Avalon-MM write fields
//   avmm_write         Avalon-MM write strobe
//   avmm_waitrequest   Avalon-MM slave stall
// -----------------------------------------------------------------------------
module avmm_single_write_fsm #(
  parameter int ADDR_WIDTH     = 17,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  input  logic [DATA_WIDTH/8-1:0] be_in,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic [ADDR_WIDTH-1:0]   avmm_address,
  output logic [DATA_WIDTH/8-1:0] avmm_byteenable,
  output logic [DATA_WIDTH-1:0]   avmm_writedata,
  output logic                    avmm_write,
  input  logic                    avmm_waitrequest
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WRITE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next_state;
  logic   w_timeout_hit;  // abort the stalled write at the next edge
  logic   w_timed_out;    // the current DONE was reached by abort

  // A timeout of zero cycles would never let a write be issued.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef AVMM_WRITE_TIMEOUT_EN
  localparam int                   CNT_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [CNT_WIDTH-1:0] r_wait_cnt;
  logic                 r_timed_out;

  // Counting stalled cycles only: the write has already been high for
  // r_wait_cnt+1 cycles, so a stall at CNT_LAST is the final allowed cycle.
  // Acceptance on that cycle (waitrequest=0) naturally wins.
  assign w_timeout_hit = (r_state == S_WRITE) && avmm_waitrequest &&
                         (r_wait_cnt == CNT_LAST);
  assign w_timed_out   = r_timed_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt  <= '0;
      r_timed_out <= 1'b0;
    end else begin
      // Set only on the abort edge, so it is high exactly in the DONE cycle
      // that follows an abort.
      r_timed_out <= w_timeout_hit;
      if ((r_state == S_IDLE) && start) begin
        r_wait_cnt <= '0;
      end else if ((r_state == S_WRITE) && avmm_waitrequest) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign w_timed_out   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of process order.
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default first so no path leaves w_next_state unassigned, which
    // would infer a latch.
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_WRITE;
      S_WRITE: if (!avmm_waitrequest || w_timeout_hit) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded from registered state only; start and waitrequest
  // never reach an output combinationally. Reset forces S_IDLE, so
  // avmm_write drops as soon as rst_n falls.
  always_comb begin
    busy       = (r_state != S_IDLE);
    avmm_write = (r_state == S_WRITE);
    done       = (r_state == S_DONE);
    error      = (r_state == S_DONE) && w_timed_out;
  end

  // Transaction fields: loaded only by an accepted start, so a start seen in
  // WRITE or DONE cannot disturb a transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: these drive the bus directly, so they are reset to give the
      // slave defined values; a pure data buffer would not need it.
      avmm_address    <= '0;
      avmm_byteenable <= '0;
      avmm_writedata  <= '0;
    end else if ((r_state == S_IDLE) && start) begin
      avmm_address    <= addr_in;
      avmm_byteenable <= be_in;
      avmm_writedata  <= data_in;
    end
  end

endmodule
